// File: rtl/drop_controller.sv
// drop_controller: falling-block game sequencer; define DROP_CONTROLLER_HARD_DROP_EN to add the hardDrop port
module drop_controller #(
  parameter int DROP_TICKS = 25000000,
  parameter int SPAWN_X    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         bottomTouch,
  input  logic [0:399] lockField,
  input  logic         lineClear,
  input  logic         spawnCollide,
`ifdef DROP_CONTROLLER_HARD_DROP_EN
  input  logic         hardDrop,
`endif
  output logic [0:399] field,
  output logic [4:0]   blockX,
  output logic [4:0]   blockY,
  output logic         newBlockReq,
  output logic [15:0]  lineCount,
  output logic         gameOver
);
  localparam int TW = (DROP_TICKS > 2) ? $clog2(DROP_TICKS) : 1;
  localparam logic [TW-1:0] TC = TW'(DROP_TICKS - 1);
  typedef enum logic [2:0] {IDLE, SPAWN, FALL, LOCK, OVER} state_t;
  state_t state, state_n;
  logic [0:399] field_n;
  logic [4:0] bx_n, by_n;
  logic [15:0] lc_n;
  logic [TW-1:0] timer, timer_n;
  logic drop, drop_n, hd_req, step;
`ifdef DROP_CONTROLLER_HARD_DROP_EN
  assign hd_req = hardDrop;
`else
  assign hd_req = 1'b0;
`endif
  // a gravity step happens at terminal count, or every cycle once a hard drop is under way
  assign step = (timer == TC) || hd_req || drop;
  // state and all registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      field       <= '0;
      blockX      <= '0;
      blockY      <= '0;
      lineCount   <= '0;
      gameOver    <= 1'b0;
      newBlockReq <= 1'b0;
      timer       <= '0;
      drop        <= 1'b0;
    end else begin
      state       <= state_n;
      field       <= field_n;
      blockX      <= bx_n;
      blockY      <= by_n;
      lineCount   <= lc_n;
      gameOver    <= (state_n == OVER);
      newBlockReq <= (state_n == SPAWN);
      timer       <= timer_n;
      drop        <= drop_n;
    end
  end
  // next state and next register values; entering SPAWN reloads the block and the drop timer
  always_comb begin
    state_n = state;
    field_n = field;
    bx_n    = blockX;
    by_n    = blockY;
    lc_n    = lineCount;
    timer_n = timer;
    drop_n  = drop;
    case (state)
      IDLE, OVER: if (start) begin
        state_n = SPAWN;
        field_n = '0;
        lc_n    = '0;
      end
      SPAWN: state_n = spawnCollide ? OVER : FALL;
      FALL: begin
        drop_n  = drop | hd_req;
        timer_n = (drop | hd_req) ? TC : (timer == TC) ? '0 : timer + 1'b1;
        if (step) begin
          if (bottomTouch) state_n = LOCK;
          else if (blockY < 5'd19) by_n = blockY + 5'd1;
        end
      end
      LOCK: begin
        state_n = SPAWN;
        field_n = lockField;
        lc_n    = (lineClear && lineCount != 16'hFFFF) ? lineCount + 16'd1 : lineCount;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == SPAWN) begin
      bx_n    = 5'(SPAWN_X);
      by_n    = '0;
      timer_n = '0;
      drop_n  = 1'b0;
    end
  end
endmodule

// File: tb/tb_drop_controller.sv
// tb_drop_controller: vector table plus scoreboard checks of drop_controller with DROP_TICKS=4
module tb_drop_controller;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bottomTouch = 1'b0, lineClear = 1'b0, spawnCollide = 1'b0;
  logic [0:399] lockField = '0;
`ifdef DROP_CONTROLLER_HARD_DROP_EN
  logic hardDrop = 1'b0;
`endif
  logic [0:399] field;
  logic [4:0] blockX, blockY;
  logic newBlockReq, gameOver;
  logic [15:0] lineCount;
  localparam logic [0:399] B399 = {399'b0, 1'b1};

  always #5 clk = ~clk;

  drop_controller #(.DROP_TICKS(4), .SPAWN_X(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bottomTouch(bottomTouch),
    .lockField(lockField), .lineClear(lineClear), .spawnCollide(spawnCollide),
`ifdef DROP_CONTROLLER_HARD_DROP_EN
    .hardDrop(hardDrop),
`endif
    .field(field), .blockX(blockX), .blockY(blockY), .newBlockReq(newBlockReq),
    .lineCount(lineCount), .gameOver(gameOver)
  );

  typedef struct {
    logic [4:0] bx, by;
    logic nbr;
    logic [15:0] cnt;
    logic go, fd;
  } exp_t;
  typedef struct {
    logic st, bt, lf, lc, sc;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t v[20];
  int n_vec = 0, n_err = 0;

  function automatic exp_t ex(input int bx, input int by, input int nbr, input int cnt, input int go, input int fd);
    ex.bx = 5'(bx); ex.by = 5'(by); ex.nbr = 1'(nbr); ex.cnt = 16'(cnt); ex.go = 1'(go); ex.fd = 1'(fd);
  endfunction

  function automatic vec_t vc(input int st, input int bt, input int lf, input int lc, input int sc, input exp_t e);
    vc.st = 1'(st); vc.bt = 1'(bt); vc.lf = 1'(lf); vc.lc = 1'(lc); vc.sc = 1'(sc); vc.e = e;
  endfunction

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (blockX !== e.bx || blockY !== e.by || newBlockReq !== e.nbr || lineCount !== e.cnt ||
        gameOver !== e.go || field !== (e.fd ? B399 : '0)) begin
      n_err++;
      $display("FAIL %s: got bx=%0d by=%0d nbr=%b lc=%0d go=%b f399=%b ones=%0d; want bx=%0d by=%0d nbr=%b lc=%0d go=%b f399=%b ones=%0d",
               name, blockX, blockY, newBlockReq, lineCount, gameOver, field[399], $countones(field),
               e.bx, e.by, e.nbr, e.cnt, e.go, e.fd, e.fd ? 1 : 0);
    end
  endtask

  task automatic step(input string name, input exp_t e);
    sb.push_back(e);
    @(posedge clk); #1;
    check(name, sb.pop_front());
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    v[0]  = vc(0,0,0,0,0, ex(0,0,0,0,0,0));
    v[1]  = vc(1,0,0,0,0, ex(8,0,1,0,0,0));
    v[2]  = vc(1,0,0,0,0, ex(8,0,0,0,0,0));
    v[3]  = vc(0,0,0,0,0, ex(8,0,0,0,0,0));
    v[4]  = vc(0,0,0,0,0, ex(8,0,0,0,0,0));
    v[5]  = vc(0,0,0,0,0, ex(8,0,0,0,0,0));
    v[6]  = vc(0,0,0,0,0, ex(8,1,0,0,0,0));
    v[7]  = vc(1,0,0,0,0, ex(8,1,0,0,0,0));
    v[8]  = vc(0,0,0,0,0, ex(8,1,0,0,0,0));
    v[9]  = vc(0,0,0,0,0, ex(8,1,0,0,0,0));
    v[10] = vc(0,0,0,0,0, ex(8,2,0,0,0,0));
    v[11] = vc(0,1,0,0,0, ex(8,2,0,0,0,0));
    v[12] = vc(0,1,0,0,0, ex(8,2,0,0,0,0));
    v[13] = vc(0,1,0,0,0, ex(8,2,0,0,0,0));
    v[14] = vc(0,1,0,0,0, ex(8,2,0,0,0,0));
    v[15] = vc(0,0,1,1,0, ex(8,0,1,1,0,1));
    v[16] = vc(0,0,0,0,1, ex(8,0,0,1,1,1));
    v[17] = vc(0,0,0,1,0, ex(8,0,0,1,1,1));
    v[18] = vc(1,0,0,0,0, ex(8,0,1,0,0,0));
    v[19] = vc(0,0,0,0,0, ex(8,0,0,0,0,0));

    #12;
    check("reset", ex(0,0,0,0,0,0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      start = v[i].st; bottomTouch = v[i].bt; lineClear = v[i].lc; spawnCollide = v[i].sc;
      lockField = v[i].lf ? B399 : '0;
      step($sformatf("vec%0d", i), v[i].e);
    end
    start = 1'b0; bottomTouch = 1'b0; lineClear = 1'b0; spawnCollide = 1'b0; lockField = '0;

    begin : mid_fall_reset
      int n;
      n = 0;
      while (blockY != 5'd5 && n < 40) begin idle_cycle(); n++; end
      if (blockY != 5'd5) begin
        n_vec++; n_err++;
        $display("FAIL reach_y5: got by=%0d after %0d cycles, want 5", blockY, n);
      end
      idle_cycle();
      rst_n = 1'b0;
      #1;
      check("async_reset", ex(0,0,0,0,0,0));
      idle_cycle();
      rst_n = 1'b1;
    end

    for (int i = 0; i < 3; i++) step($sformatf("idle_after_reset%0d", i), ex(0,0,0,0,0,0));

    start = 1'b1;
    step("restart_spawn", ex(8,0,1,0,0,0));
    start = 1'b0;
    for (int i = 0; i < 90; i++) idle_cycle();
    check("y_cap19", ex(8,19,0,0,0,0));

    begin : lock_at_bottom
      int n;
      bottomTouch = 1'b1; lockField = B399; lineClear = 1'b0;
      n = 0;
      while (!newBlockReq && n < 8) begin idle_cycle(); n++; end
      bottomTouch = 1'b0;
      check("lock_no_clear", ex(8,0,1,0,0,1));
    end

`ifdef DROP_CONTROLLER_HARD_DROP_EN
    step("hd_fall", ex(8,0,0,0,0,1));
    hardDrop = 1'b1;
    step("hd_first", ex(8,1,0,0,0,1));
    hardDrop = 1'b0;
    for (int i = 0; i < 15; i++) idle_cycle();
    check("hd_y16", ex(8,16,0,0,0,1));
    bottomTouch = 1'b1;
    step("hd_lock", ex(8,16,0,0,0,1));
    step("hd_respawn", ex(8,0,1,0,0,1));
    bottomTouch = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
